// File: rtl/axi_slave_write_channel.sv
// AXI-style write slave: accepts one address phase, turns each accepted beat into a
// single-cycle memory write, and returns one response per burst (single outstanding).
module axi_slave_write_channel #(
    parameter int ADDR_WIDTH          = 32,
    parameter int WRITE_CHANNEL_WIDTH = 32,
    parameter int WRITE_BURST_LEN     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    input  logic [WRITE_BURST_LEN-1:0]     AWLEN,
    input  logic [2:0]                     AWSIZE,
    input  logic [1:0]                     AWBURST,
    output logic                           AWREADY,
    input  logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
    input  logic                           WVALID,
    input  logic                           WLAST,
    output logic                           WREADY,
    input  logic                           BREADY,
    output logic                           BVALID,
    output logic                           BRESP,
    input  logic                           mem_wready,
    output logic                           mem_wen,
    output logic [ADDR_WIDTH-1:0]          mem_waddr,
    output logic [WRITE_CHANNEL_WIDTH-1:0] mem_wdata,
    output logic                           busy
);

    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(WRITE_CHANNEL_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
    logic [WRITE_BURST_LEN-1:0] len_q, len_d;
    logic                       fixed_q, fixed_d;
    logic [WRITE_BURST_LEN-1:0] beat_cnt_q, beat_cnt_d;
    logic                       err_q, err_d;
    logic                       beat;
    logic                       last_beat;

    // AWSIZE is part of the reduced AXI set but carries no meaning here.
    logic unused_awsize;
    assign unused_awsize = ^AWSIZE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            fixed_q    <= 1'b0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            fixed_q    <= fixed_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        fixed_d    = fixed_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        BRESP      = 1'b1;
        busy       = (state_q != IDLE);
        last_beat  = (beat_cnt_q == len_q);

        case (state_q)
            IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    cur_addr_d = AWADDR;
                    len_d      = AWLEN;
                    fixed_d    = (AWBURST == 2'b00);
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                WREADY = mem_wready;
            end
            RESP: begin
                BVALID = 1'b1;
                BRESP  = !err_q;
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        beat = WVALID && WREADY;

        // Burst length is set by len alone; a misplaced WLAST only flags the response.
        if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (!fixed_q) begin
                cur_addr_d = cur_addr_q + BEAT_BYTES;
            end
            err_d = err_q | (WLAST != last_beat);
            if (last_beat) begin
                state_d = RESP;
            end
        end

        mem_wen   = beat;
        mem_waddr = cur_addr_q;
        mem_wdata = beat ? WDATA : '0;
    end

endmodule
